// File: rtl/game_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// game_ctrl_pkg : shared game-flow state encoding (also decoded by the display)
// Rev 1.0
// ============================================================================
package game_ctrl_pkg;

  localparam int c_state_w = 3;

  typedef enum logic [c_state_w-1:0] {
    ST_RESTART = 3'd0,
    ST_START   = 3'd1,
    ST_PLAY    = 3'd2,
    ST_DIE     = 3'd3,
    ST_PAUSE   = 3'd4,
    ST_OVER    = 3'd5
  } game_state_t;

endpackage
`default_nettype wire

// File: rtl/flash_timer.sv
`default_nettype none
// ============================================================================
// flash_timer : shared state timer with die-flash toggle and end-of-death marks
// Rev 1.0
// ============================================================================
module flash_timer #(
  parameter int FLASH_HALF_CYC = 25_000_000,
  parameter int FLASH_TOGGLES  = 6,
  parameter int DIE_CYC        = 200_000_000,
  parameter int CNT_W          = $clog2(DIE_CYC + 1)
) (
  input  logic             CLK_50M,
  input  logic             RSTn,
  input  logic             clr,
  input  logic             run,
  output logic             flash,
  output logic             done,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0]         r_cnt;
  logic [FLASH_TOGGLES-1:0] w_mark;

  always_ff @(posedge CLK_50M or negedge RSTn) begin
    if (!RSTn) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  genvar k;
  generate
    for (k = 0; k < FLASH_TOGGLES; k++) begin : g_mark
      localparam logic [CNT_W-1:0] c_mark = CNT_W'((k + 1) * FLASH_HALF_CYC);
      assign w_mark[k] = (r_cnt == c_mark);
    end
  endgenerate

  // flash is a one-cycle "invert the display enable now" strobe
  assign flash = run & (|w_mark);
  assign done  = run & (r_cnt == CNT_W'(DIE_CYC - 1));
  assign cnt   = r_cnt;

endmodule
`default_nettype wire

// File: rtl/game_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// game_ctrl_fsm : snake game-flow controller (START/PLAY/PAUSE/DIE/RESTART/OVER)
// Rev 1.0
// ============================================================================
module game_ctrl_fsm
  import game_ctrl_pkg::*;
#(
  parameter int N_KEYS         = 4,
  parameter int LIVES          = 3,
  parameter int LIVES_W        = 2,
  parameter int FLASH_HALF_CYC = 25_000_000,
  parameter int FLASH_TOGGLES  = 6,
  parameter int DIE_CYC        = 200_000_000,
  parameter int RESTART_CYC    = 6,
  parameter bit PAUSE_EN       = 1'b1
) (
  input  logic               CLK_50M,
  input  logic               RSTn,
  input  logic [N_KEYS-1:0]  key_press,
  input  logic               pause_press,
  input  logic               hit_wall,
  input  logic               hit_body,
  output logic [2:0]         game_status,
  output logic               die_flash,
  output logic               restart,
  output logic [LIVES_W-1:0] lives_left,
  output logic               game_over
);

  localparam int                 CNT_W          = $clog2(DIE_CYC + 1);
  localparam logic [LIVES_W-1:0] c_lives        = LIVES_W'(LIVES);
  localparam logic [CNT_W-1:0]   c_restart_last = CNT_W'(RESTART_CYC - 1);

  game_state_t        r_state, w_state_nxt;
  logic               r_die_flash, w_die_flash_nxt;
  logic               r_restart, w_restart_nxt;
  logic               r_game_over, w_game_over_nxt;
  logic [LIVES_W-1:0] r_lives, w_lives_nxt;
  logic               w_clr, w_run, w_toggle, w_done;
  logic [CNT_W-1:0]   w_cnt;
  logic               w_key, w_hit;

  assign w_key = |key_press;
  assign w_hit = hit_wall | hit_body;
  assign w_clr = (w_state_nxt != r_state);

  flash_timer #(
    .FLASH_HALF_CYC (FLASH_HALF_CYC),
    .FLASH_TOGGLES  (FLASH_TOGGLES),
    .DIE_CYC        (DIE_CYC),
    .CNT_W          (CNT_W)
  ) u_flash_timer (
    .CLK_50M (CLK_50M),
    .RSTn    (RSTn),
    .clr     (w_clr),
    .run     (w_run),
    .flash   (w_toggle),
    .done    (w_done),
    .cnt     (w_cnt)
  );

  always_ff @(posedge CLK_50M or negedge RSTn) begin
    if (!RSTn) begin
      r_state     <= ST_START;
      r_die_flash <= 1'b1;
      r_restart   <= 1'b0;
      r_lives     <= c_lives;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_die_flash <= w_die_flash_nxt;
      r_restart   <= w_restart_nxt;
      r_lives     <= w_lives_nxt;
      r_game_over <= w_game_over_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_die_flash_nxt = r_die_flash;
    w_restart_nxt   = r_restart;
    w_lives_nxt     = r_lives;
    w_game_over_nxt = r_game_over;
    w_run           = 1'b0;
    case (r_state)
      ST_RESTART: begin
        w_run = 1'b1;
        if (w_cnt == c_restart_last) begin
          w_state_nxt   = ST_START;
          w_restart_nxt = 1'b0;
        end
      end
      ST_START: begin
        if (w_key) w_state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        // a collision takes priority over a pause request in the same cycle
        if (w_hit) begin
          w_state_nxt = ST_DIE;
          w_lives_nxt = (r_lives == '0) ? '0 : r_lives - LIVES_W'(1);
        end else if (pause_press && PAUSE_EN) begin
          w_state_nxt = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (pause_press) w_state_nxt = ST_PLAY;
      end
      ST_DIE: begin
        w_run = 1'b1;
        if (w_toggle) w_die_flash_nxt = ~r_die_flash;
        if (w_done) begin
          w_die_flash_nxt = 1'b1;
          if (r_lives == '0) begin
            w_state_nxt     = ST_OVER;
            w_game_over_nxt = 1'b1;
          end else begin
            w_state_nxt   = ST_RESTART;
            w_restart_nxt = 1'b1;
          end
        end
      end
      ST_OVER: begin
        w_die_flash_nxt = 1'b1;
        w_game_over_nxt = 1'b1;
        if (w_key) begin
          w_state_nxt     = ST_RESTART;
          w_lives_nxt     = c_lives;
          w_game_over_nxt = 1'b0;
          w_restart_nxt   = 1'b1;
        end
      end
      default: begin
        w_state_nxt     = ST_START;
        w_die_flash_nxt = 1'b1;
        w_restart_nxt   = 1'b0;
        w_lives_nxt     = c_lives;
        w_game_over_nxt = 1'b0;
      end
    endcase
  end

  assign game_status = r_state;
  assign die_flash   = r_die_flash;
  assign restart     = r_restart;
  assign lives_left  = r_lives;
  assign game_over   = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// tb_game_ctrl_fsm : scenario and randomized checks of game_ctrl_fsm
// Rev 1.0
// ============================================================================
module tb_game_ctrl_fsm;

  localparam int FHC   = 4;
  localparam int TOG   = 6;
  localparam int DIE   = 32;
  localparam int RC    = 3;
  localparam int LIVES = 2;
  localparam int LW    = 2;
  localparam int NK    = 4;

  localparam int S_RESTART = 0, S_START = 1, S_PLAY = 2, S_DIE = 3, S_PAUSE = 4, S_OVER = 5;

  logic          CLK_50M = 1'b0;
  logic          RSTn = 1'b0;
  logic [NK-1:0] key_press = '0;
  logic          pause_press = 1'b0;
  logic          hit_wall = 1'b0;
  logic          hit_body = 1'b0;

  logic [2:0]    game_status, game_status_b;
  logic          die_flash, die_flash_b;
  logic          restart, restart_b;
  logic [LW-1:0] lives_left, lives_left_b;
  logic          game_over, game_over_b;

  int checks = 0;
  int errors = 0;

  // reference model: spec-level state code, cycles since entering it, lives
  int m_st, m_age, m_lives;

  always #10 CLK_50M = ~CLK_50M;

  game_ctrl_fsm #(
    .N_KEYS(NK), .LIVES(LIVES), .LIVES_W(LW), .FLASH_HALF_CYC(FHC), .FLASH_TOGGLES(TOG),
    .DIE_CYC(DIE), .RESTART_CYC(RC), .PAUSE_EN(1'b1)
  ) dut (
    .CLK_50M(CLK_50M), .RSTn(RSTn), .key_press(key_press), .pause_press(pause_press),
    .hit_wall(hit_wall), .hit_body(hit_body), .game_status(game_status), .die_flash(die_flash),
    .restart(restart), .lives_left(lives_left), .game_over(game_over)
  );

  game_ctrl_fsm #(
    .N_KEYS(NK), .LIVES(LIVES), .LIVES_W(LW), .FLASH_HALF_CYC(FHC), .FLASH_TOGGLES(TOG),
    .DIE_CYC(DIE), .RESTART_CYC(RC), .PAUSE_EN(1'b0)
  ) dut_nopause (
    .CLK_50M(CLK_50M), .RSTn(RSTn), .key_press(key_press), .pause_press(pause_press),
    .hit_wall(hit_wall), .hit_body(hit_body), .game_status(game_status_b), .die_flash(die_flash_b),
    .restart(restart_b), .lives_left(lives_left_b), .game_over(game_over_b)
  );

  function automatic logic exp_flash();
    int n;
    if (m_st != S_DIE || m_age == 0) return 1'b1;
    n = (m_age - 1) / FHC;
    if (n > TOG) n = TOG;
    return logic'(n % 2 == 0);
  endfunction

  task automatic model_reset();
    m_st = S_START; m_age = 0; m_lives = LIVES;
  endtask

  task automatic model_step();
    int nst;
    nst = m_st;
    case (m_st)
      S_RESTART: if (m_age == RC - 1) nst = S_START;
      S_START:   if (|key_press) nst = S_PLAY;
      S_PLAY: begin
        if (hit_wall || hit_body) begin
          nst = S_DIE;
          if (m_lives > 0) m_lives--;
        end else if (pause_press) nst = S_PAUSE;
      end
      S_PAUSE:   if (pause_press) nst = S_PLAY;
      S_DIE:     if (m_age == DIE - 1) nst = (m_lives == 0) ? S_OVER : S_RESTART;
      S_OVER: begin
        if (|key_press) begin nst = S_RESTART; m_lives = LIVES; end
      end
      default: nst = S_START;
    endcase
    m_age = (nst != m_st) ? 0 : m_age + 1;
    m_st  = nst;
  endtask

  task automatic tick();
    @(posedge CLK_50M);
    if (!RSTn) model_reset(); else model_step();
    #1;
  endtask

  task automatic clear_inputs();
    key_press = '0; pause_press = 1'b0; hit_wall = 1'b0; hit_body = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    RSTn = 1'b0;
    model_reset();
    tick(); tick();
    RSTn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (game_status !== 3'd1) begin errors++; $display("FAIL reset_status: got %0d expected 1", game_status); end
    checks++; if (die_flash !== 1'b1) begin errors++; $display("FAIL reset_flash: got %b expected 1", die_flash); end
    checks++; if (restart !== 1'b0) begin errors++; $display("FAIL reset_restart: got %b expected 0", restart); end
    checks++; if (lives_left !== 2'(LIVES)) begin errors++; $display("FAIL reset_lives: got %0d expected %0d", lives_left, LIVES); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_over: got %b expected 0", game_over); end
    checks++; if (game_status_b !== 3'd1) begin errors++; $display("FAIL reset_status_b: got %0d expected 1", game_status_b); end
  endtask

  task automatic test_start_play();
    pause_press = 1'b1; hit_wall = 1'b1; hit_body = 1'b1;
    tick();
    clear_inputs();
    checks++; if (game_status !== 3'd1) begin errors++; $display("FAIL start_ignore: got %0d expected 1", game_status); end
    key_press = 4'b0100;
    tick();
    key_press = '0;
    checks++; if (game_status !== 3'd2) begin errors++; $display("FAIL start_to_play: got %0d expected 2", game_status); end
    checks++; if (lives_left !== 2'd2) begin errors++; $display("FAIL play_lives: got %0d expected 2", lives_left); end
  endtask

  task automatic test_die_restart();
    logic prev;
    int   toggles;
    hit_wall = 1'b1;
    tick();
    hit_wall = 1'b0;
    checks++; if (game_status !== 3'd3) begin errors++; $display("FAIL die_enter: got %0d expected 3", game_status); end
    checks++; if (lives_left !== 2'd1) begin errors++; $display("FAIL die_lives: got %0d expected 1", lives_left); end
    prev = die_flash;
    toggles = 0;
    for (int i = 1; i < DIE; i++) begin
      tick();
      if (die_flash !== prev) toggles++;
      prev = die_flash;
      checks++; if (die_flash !== exp_flash()) begin errors++; $display("FAIL die_flash age %0d: got %b expected %b", i, die_flash, exp_flash()); end
      checks++; if (game_status !== 3'd3) begin errors++; $display("FAIL die_hold age %0d: got %0d expected 3", i, game_status); end
    end
    checks++; if (toggles !== TOG) begin errors++; $display("FAIL die_toggles: got %0d expected %0d", toggles, TOG); end
    tick();
    for (int i = 0; i < RC; i++) begin
      checks++; if (game_status !== 3'd0) begin errors++; $display("FAIL restart_status %0d: got %0d expected 0", i, game_status); end
      checks++; if (restart !== 1'b1) begin errors++; $display("FAIL restart_strobe %0d: got %b expected 1", i, restart); end
      checks++; if (die_flash !== 1'b1) begin errors++; $display("FAIL restart_flash %0d: got %b expected 1", i, die_flash); end
      tick();
    end
    checks++; if (game_status !== 3'd1) begin errors++; $display("FAIL restart_done: got %0d expected 1", game_status); end
    checks++; if (restart !== 1'b0) begin errors++; $display("FAIL restart_low: got %b expected 0", restart); end
  endtask

  task automatic test_game_over();
    key_press = 4'b0001;
    tick();
    key_press = '0;
    hit_body = 1'b1;
    tick();
    hit_body = 1'b0;
    checks++; if (game_status !== 3'd3) begin errors++; $display("FAIL over_die: got %0d expected 3", game_status); end
    checks++; if (lives_left !== 2'd0) begin errors++; $display("FAIL over_lives0: got %0d expected 0", lives_left); end
    for (int i = 0; i < DIE; i++) begin
      key_press = 4'($urandom_range(0, 15));
      pause_press = 1'($urandom_range(0, 1));
      hit_wall = 1'($urandom_range(0, 1));
      hit_body = 1'($urandom_range(0, 1));
      tick();
    end
    clear_inputs();
    checks++; if (game_status !== 3'd5) begin errors++; $display("FAIL over_status: got %0d expected 5", game_status); end
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL over_flag: got %b expected 1", game_over); end
    checks++; if (die_flash !== 1'b1) begin errors++; $display("FAIL over_flash: got %b expected 1", die_flash); end
    checks++; if (restart !== 1'b0) begin errors++; $display("FAIL over_restart: got %b expected 0", restart); end
    key_press = 4'b0001;
    tick();
    key_press = '0;
    checks++; if (game_status !== 3'd0) begin errors++; $display("FAIL over_to_restart: got %0d expected 0", game_status); end
    checks++; if (lives_left !== 2'd2) begin errors++; $display("FAIL over_lives_reload: got %0d expected 2", lives_left); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL over_clear: got %b expected 0", game_over); end
    repeat (RC) tick();
    checks++; if (game_status !== 3'd1) begin errors++; $display("FAIL over_back_start: got %0d expected 1", game_status); end
  endtask

  task automatic test_pause();
    key_press = 4'b1000;
    tick();
    key_press = '0;
    pause_press = 1'b1;
    tick();
    pause_press = 1'b0;
    checks++; if (game_status !== 3'd4) begin errors++; $display("FAIL pause_enter: got %0d expected 4", game_status); end
    hit_wall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) key_press = 4'b0010; else key_press = '0;
      tick();
      checks++; if (game_status !== 3'd4) begin errors++; $display("FAIL pause_hold %0d: got %0d expected 4", i, game_status); end
    end
    clear_inputs();
    checks++; if (lives_left !== 2'd2) begin errors++; $display("FAIL pause_lives: got %0d expected 2", lives_left); end
    pause_press = 1'b1;
    tick();
    pause_press = 1'b0;
    checks++; if (game_status !== 3'd2) begin errors++; $display("FAIL pause_resume: got %0d expected 2", game_status); end
  endtask

  task automatic test_hit_beats_pause();
    hit_wall = 1'b1; pause_press = 1'b1;
    tick();
    clear_inputs();
    checks++; if (game_status !== 3'd3) begin errors++; $display("FAIL hit_vs_pause: got %0d expected 3", game_status); end
    checks++; if (lives_left !== 2'd1) begin errors++; $display("FAIL hit_vs_pause_lives: got %0d expected 1", lives_left); end
    repeat (DIE) tick();
    checks++; if (game_status !== 3'd0) begin errors++; $display("FAIL hit_vs_pause_restart: got %0d expected 0", game_status); end
    repeat (RC) tick();
    checks++; if (game_status !== 3'd1) begin errors++; $display("FAIL hit_vs_pause_start: got %0d expected 1", game_status); end
  endtask

  task automatic test_pause_disabled();
    do_reset();
    key_press = 4'b0100;
    tick();
    key_press = '0;
    checks++; if (game_status_b !== 3'd2) begin errors++; $display("FAIL nopause_play: got %0d expected 2", game_status_b); end
    pause_press = 1'b1;
    tick();
    pause_press = 1'b0;
    checks++; if (game_status_b !== 3'd2) begin errors++; $display("FAIL nopause_ignore: got %0d expected 2", game_status_b); end
    checks++; if (game_status !== 3'd4) begin errors++; $display("FAIL pause_en_contrast: got %0d expected 4", game_status); end
    pause_press = 1'b1;
    tick();
    pause_press = 1'b0;
    checks++; if (game_status !== 3'd2) begin errors++; $display("FAIL pause_en_resume: got %0d expected 2", game_status); end
  endtask

  task automatic test_async_reset();
    bit found;
    hit_wall = 1'b1;
    tick();
    hit_wall = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (m_st == S_DIE && m_age >= 10 && exp_flash() == 1'b0) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL async_setup: got no dark DIE cycle expected one within 40 cycles"); end
    checks++; if (die_flash !== 1'b0) begin errors++; $display("FAIL async_pre_flash: got %b expected 0", die_flash); end
    #3;
    RSTn = 1'b0;
    model_reset();
    #1;
    checks++; if (die_flash !== 1'b1) begin errors++; $display("FAIL async_flash: got %b expected 1", die_flash); end
    checks++; if (game_status !== 3'd1) begin errors++; $display("FAIL async_status: got %0d expected 1", game_status); end
    checks++; if (lives_left !== 2'd2) begin errors++; $display("FAIL async_lives: got %0d expected 2", lives_left); end
    checks++; if (die_flash_b !== 1'b1) begin errors++; $display("FAIL async_flash_b: got %b expected 1", die_flash_b); end
    tick();
    RSTn = 1'b1;
    key_press = 4'b0010;
    tick();
    key_press = '0;
    hit_body = 1'b1;
    tick();
    hit_body = 1'b0;
    repeat (DIE) tick();
    checks++; if (restart !== 1'b1) begin errors++; $display("FAIL async_pre_restart: got %b expected 1", restart); end
    #3;
    RSTn = 1'b0;
    model_reset();
    #1;
    checks++; if (restart !== 1'b0) begin errors++; $display("FAIL async_restart: got %b expected 0", restart); end
    checks++; if (game_status !== 3'd1) begin errors++; $display("FAIL async_restart_status: got %0d expected 1", game_status); end
    tick();
    RSTn = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      key_press   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      pause_press = ($urandom_range(0, 11) == 0);
      hit_wall    = ($urandom_range(0, 19) == 0);
      hit_body    = ($urandom_range(0, 29) == 0);
      tick();
      checks++; if (game_status !== 3'(m_st)) begin errors++; $display("FAIL rnd_status cyc %0d: got %0d expected %0d", c, game_status, m_st); end
      checks++; if (lives_left !== LW'(m_lives)) begin errors++; $display("FAIL rnd_lives cyc %0d: got %0d expected %0d", c, lives_left, m_lives); end
      checks++; if (die_flash !== exp_flash()) begin errors++; $display("FAIL rnd_flash cyc %0d: got %b expected %b", c, die_flash, exp_flash()); end
      checks++; if (restart !== (m_st == S_RESTART)) begin errors++; $display("FAIL rnd_restart cyc %0d: got %b expected %b", c, restart, m_st == S_RESTART); end
      checks++; if (game_over !== (m_st == S_OVER)) begin errors++; $display("FAIL rnd_over cyc %0d: got %b expected %b", c, game_over, m_st == S_OVER); end
    end
    clear_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_start_play();
    test_die_restart();
    test_game_over();
    test_pause();
    test_hit_beats_pause();
    test_pause_disabled();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
